regfile_sb: RTL and testbench

Parametrised, clocked integer register file for the MIPS datapath. It replaces the level-sensitive register array. It adds two write ports: port A for ALU writeback and port B for load/multicycle writeback. Reads are write-first with bypass, register 0 is hardwired to zero, and a per-register scoreboard tracks destinations claimed by in-flight multicycle operations. It sits between decode (read ports, claims) and writeback (write ports), and exports the low registers for the board debug display.

---
 rtl/regfile_sb.sv | 116 +++++++++++
 tb/tb_regfile_sb.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Two-write-port integer register file with write-first bypass, hardwired zero
// register and a per-register scoreboard for in-flight multicycle destinations.
module regfile_sb #(
  parameter int DATA_W  = 32,
  parameter int NUM_REG = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_DBG = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         rs1_addr,
  input  logic [ADDR_W-1:0]         rs2_addr,
  output logic [DATA_W-1:0]         rs1_data,
  output logic [DATA_W-1:0]         rs2_data,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  input  logic                      wa_en,
  input  logic [ADDR_W-1:0]         wa_addr,
  input  logic [DATA_W-1:0]         wa_data,
  input  logic                      wb_en,
  input  logic [ADDR_W-1:0]         wb_addr,
  input  logic [DATA_W-1:0]         wb_data,
  input  logic                      claim_en,
  input  logic [ADDR_W-1:0]         claim_addr,
  output logic [ADDR_W:0]           pend_cnt,
  output logic                      wr_conflict,
  output logic [NUM_DBG*DATA_W-1:0] dbg_regs
);

  logic [DATA_W-1:0]  r_regs [NUM_REG];
  logic [NUM_REG-1:0] r_pend;
  logic [ADDR_W:0]    r_pend_cnt;
  logic               r_wr_conflict;

  logic [NUM_REG-1:0] w_pend_nxt;
  logic [ADDR_W:0]    w_pend_cnt_nxt;
  logic               w_conflict_nxt;
  logic               w_rs1_wb_hit;
  logic               w_rs2_wb_hit;

  // Scoreboard next state: a claim beats a same-cycle port B clear.
  always_comb begin
    w_pend_nxt     = r_pend;
    w_pend_cnt_nxt = '0;
    for (int i = 1; i < NUM_REG; i++) begin
      if (claim_en && claim_addr == ADDR_W'(i))
        w_pend_nxt[i] = 1'b1;
      else if (wb_en && wb_addr == ADDR_W'(i))
        w_pend_nxt[i] = 1'b0;
    end
    w_pend_nxt[0] = 1'b0;
    // NOTE: blocking '=' accumulates within one combinational pass; every
    // output gets a default above so no latch is inferred.
    for (int i = 1; i < NUM_REG; i++)
      w_pend_cnt_nxt = w_pend_cnt_nxt + (ADDR_W+1)'(w_pend_nxt[i]);
  end

  assign w_conflict_nxt = wa_en && wb_en && (wa_addr == wb_addr) && (wa_addr != '0);

  // NOTE: the array is reset like ordinary flops because software observes
  // the zeroed state (and dbg_regs) right after reset; it cannot map to RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REG; i++)
        r_regs[i] <= '0;
      r_pend        <= '0;
      r_pend_cnt    <= '0;
      r_wr_conflict <= 1'b0;
    end else begin
      for (int i = 1; i < NUM_REG; i++) begin
        if (wb_en && wb_addr == ADDR_W'(i))
          r_regs[i] <= wb_data;
        else if (wa_en && wa_addr == ADDR_W'(i))
          r_regs[i] <= wa_data;
      end
      r_pend        <= w_pend_nxt;
      r_pend_cnt    <= w_pend_cnt_nxt;
      r_wr_conflict <= w_conflict_nxt;
    end
  end

  assign w_rs1_wb_hit = wb_en && (wb_addr == rs1_addr);
  assign w_rs2_wb_hit = wb_en && (wb_addr == rs2_addr);

  // Write-first read: port B over port A over storage; no bypass in reset.
  always_comb begin
    rs1_data = r_regs[rs1_addr];
    if (rs1_addr == '0)
      rs1_data = '0;
    else if (!rst && w_rs1_wb_hit)
      rs1_data = wb_data;
    else if (!rst && wa_en && wa_addr == rs1_addr)
      rs1_data = wa_data;
  end

  always_comb begin
    rs2_data = r_regs[rs2_addr];
    if (rs2_addr == '0)
      rs2_data = '0;
    else if (!rst && w_rs2_wb_hit)
      rs2_data = wb_data;
    else if (!rst && wa_en && wa_addr == rs2_addr)
      rs2_data = wa_data;
  end

  assign rs1_busy = !rst && (rs1_addr != '0) && r_pend[rs1_addr] && !w_rs1_wb_hit;
  assign rs2_busy = !rst && (rs2_addr != '0) && r_pend[rs2_addr] && !w_rs2_wb_hit;

  assign pend_cnt    = r_pend_cnt;
  assign wr_conflict = r_wr_conflict;

  for (genvar k = 1; k <= NUM_DBG; k++) begin : g_dbg
    assign dbg_regs[k*DATA_W-1 -: DATA_W] = r_regs[k];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic
// compared against an array-based model of the register file and scoreboard.
module tb_regfile_sb;

  localparam int DATA_W  = 32;
  localparam int NUM_REG = 32;
  localparam int ADDR_W  = 5;
  localparam int NUM_DBG = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [ADDR_W-1:0]         rs1_addr, rs2_addr;
  logic [DATA_W-1:0]         rs1_data, rs2_data;
  logic                      rs1_busy, rs2_busy;
  logic                      wa_en, wb_en, claim_en;
  logic [ADDR_W-1:0]         wa_addr, wb_addr, claim_addr;
  logic [DATA_W-1:0]         wa_data, wb_data;
  logic [ADDR_W:0]           pend_cnt;
  logic                      wr_conflict;
  logic [NUM_DBG*DATA_W-1:0] dbg_regs;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [DATA_W-1:0] m_regs [NUM_REG];
  bit                m_pend [NUM_REG];
  int                m_cnt;
  bit                m_conf;

  regfile_sb #(.DATA_W(DATA_W), .NUM_REG(NUM_REG), .ADDR_W(ADDR_W), .NUM_DBG(NUM_DBG)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .pend_cnt(pend_cnt), .wr_conflict(wr_conflict), .dbg_regs(dbg_regs)
  );

  always #5 clk = ~clk;

  // Model of one rising edge given the inputs currently applied.
  task automatic model_edge();
    int cnt;
    if (rst) begin
      for (int i = 0; i < NUM_REG; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
      m_conf = 1'b0;
    end else begin
      m_conf = wa_en && wb_en && (wa_addr == wb_addr) && (wa_addr != 0);
      if (wa_en && wa_addr != 0) m_regs[wa_addr] = wa_data;
      if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
      if (wb_en && wb_addr != 0) m_pend[wb_addr] = 1'b0;
      if (claim_en && claim_addr != 0) m_pend[claim_addr] = 1'b1;
    end
    cnt = 0;
    for (int i = 0; i < NUM_REG; i++) cnt += m_pend[i];
    m_cnt = cnt;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; wa_en = 1'b0; wb_en = 1'b0; claim_en = 1'b0;
    wa_addr = '0; wb_addr = '0; claim_addr = '0;
    wa_data = '0; wb_data = '0;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [DATA_W-1:0] exp_rdata(input logic [ADDR_W-1:0] a);
    if (a == 0) return '0;
    if (!rst && wb_en && wb_addr == a) return wb_data;
    if (!rst && wa_en && wa_addr == a) return wa_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [ADDR_W-1:0] a);
    return (a != 0) && !rst && m_pend[a] && !(wb_en && wb_addr == a);
  endfunction

  function automatic logic [NUM_DBG*DATA_W-1:0] exp_dbg();
    logic [NUM_DBG*DATA_W-1:0] v;
    v = '0;
    for (int k = 1; k <= NUM_DBG; k++) v[k*DATA_W-1 -: DATA_W] = m_regs[k];
    return v;
  endfunction

  task automatic test_reset();
    idle();
    rst = 1'b1; wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h5; rs1_addr = 5'd3; rs2_addr = 5'd3;
    settle();
    n_checks++;
    if (rs1_data !== 32'h0) begin
      n_errors++; $display("FAIL reset_no_bypass: got %h want 0", rs1_data);
    end
    tick();
    idle();
    for (int a = 0; a < NUM_REG; a++) begin
      rs1_addr = ADDR_W'(a); rs2_addr = ADDR_W'(a);
      settle();
      n_checks++;
      if (rs1_data !== 32'h0 || rs2_data !== 32'h0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_read r%0d: got d1=%h d2=%h b1=%b b2=%b want all 0",
                 a, rs1_data, rs2_data, rs1_busy, rs2_busy);
      end
    end
    n_checks++;
    if (pend_cnt !== '0 || wr_conflict !== 1'b0 || dbg_regs !== '0) begin
      n_errors++;
      $display("FAIL reset_state: got cnt=%0d conf=%b dbg=%h want 0", pend_cnt, wr_conflict, dbg_regs);
    end
  endtask

  task automatic test_write_bypass();
    idle();
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF; rs1_addr = 5'd5;
    settle();
    n_checks++;
    if (rs1_data !== 32'hDEADBEEF) begin
      n_errors++; $display("FAIL bypass_a: got %h want deadbeef", rs1_data);
    end
    tick();
    idle(); rs1_addr = 5'd5;
    settle();
    n_checks++;
    if (rs1_data !== 32'hDEADBEEF || dbg_regs[159:128] !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL stored_a: got rd=%h dbg=%h want deadbeef", rs1_data, dbg_regs[159:128]);
    end
  endtask

  task automatic test_conflict();
    idle();
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h11;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h22; rs1_addr = 5'd7;
    settle();
    n_checks++;
    if (rs1_data !== 32'h22) begin
      n_errors++; $display("FAIL conflict_bypass: got %h want 22", rs1_data);
    end
    tick();
    idle(); rs1_addr = 5'd7;
    settle();
    n_checks++;
    if (rs1_data !== 32'h22 || wr_conflict !== 1'b1) begin
      n_errors++; $display("FAIL conflict_store: got rd=%h conf=%b want 22/1", rs1_data, wr_conflict);
    end
    tick();
    n_checks++;
    if (wr_conflict !== 1'b0) begin
      n_errors++; $display("FAIL conflict_pulse: got %b want 0", wr_conflict);
    end
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'h11;
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h22; rs1_addr = 5'd0;
    settle();
    n_checks++;
    if (rs1_data !== 32'h0) begin
      n_errors++; $display("FAIL r0_read: got %h want 0", rs1_data);
    end
    tick();
    idle();
    settle();
    n_checks++;
    if (wr_conflict !== 1'b0) begin
      n_errors++; $display("FAIL r0_conflict: got %b want 0", wr_conflict);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    claim_en = 1'b1; claim_addr = 5'd9; rs2_addr = 5'd9;
    settle();
    n_checks++;
    if (rs2_busy !== 1'b0) begin
      n_errors++; $display("FAIL claim_early: got busy=%b want 0", rs2_busy);
    end
    tick();
    idle(); rs2_addr = 5'd9;
    settle();
    n_checks++;
    if (rs2_busy !== 1'b1 || pend_cnt !== 6'd1) begin
      n_errors++; $display("FAIL claim_busy: got busy=%b cnt=%0d want 1/1", rs2_busy, pend_cnt);
    end
    wa_en = 1'b1; wa_addr = 5'd9; wa_data = 32'h3;
    settle();
    n_checks++;
    if (rs2_busy !== 1'b1 || rs2_data !== 32'h3) begin
      n_errors++; $display("FAIL a_keeps_busy: got busy=%b rd=%h want 1/3", rs2_busy, rs2_data);
    end
    tick();
    idle(); rs2_addr = 5'd9;
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h4;
    settle();
    n_checks++;
    if (rs2_busy !== 1'b0 || rs2_data !== 32'h4) begin
      n_errors++; $display("FAIL b_clears_busy: got busy=%b rd=%h want 0/4", rs2_busy, rs2_data);
    end
    tick();
    idle(); rs2_addr = 5'd9;
    settle();
    n_checks++;
    if (pend_cnt !== 6'd0 || rs2_busy !== 1'b0 || rs2_data !== 32'h4) begin
      n_errors++;
      $display("FAIL b_cleared: got cnt=%0d busy=%b rd=%h want 0/0/4", pend_cnt, rs2_busy, rs2_data);
    end
  endtask

  task automatic test_claim_clear();
    idle(); claim_en = 1'b1; claim_addr = 5'd4; tick();
    idle(); claim_en = 1'b1; claim_addr = 5'd6; tick();
    idle();
    claim_en = 1'b1; claim_addr = 5'd4; wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h77;
    tick();
    idle(); rs1_addr = 5'd4;
    settle();
    n_checks++;
    if (rs1_busy !== 1'b1 || pend_cnt !== 6'd2) begin
      n_errors++; $display("FAIL claim_beats_clear: got busy=%b cnt=%0d want 1/2", rs1_busy, pend_cnt);
    end
    claim_en = 1'b1; claim_addr = 5'd2; wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h66;
    tick();
    idle(); rs1_addr = 5'd2; rs2_addr = 5'd6;
    settle();
    n_checks++;
    if (pend_cnt !== 6'd2 || rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL set_and_clear: got cnt=%0d b2=%b b6=%b want 2/1/0", pend_cnt, rs1_busy, rs2_busy);
    end
  endtask

  task automatic test_reset_pending();
    idle(); rst = 1'b1; tick();
    for (int r = 1; r <= 3; r++) begin
      idle(); claim_en = 1'b1; claim_addr = ADDR_W'(r); tick();
    end
    idle();
    settle();
    n_checks++;
    if (pend_cnt !== 6'd3) begin
      n_errors++; $display("FAIL claims_cnt: got %0d want 3", pend_cnt);
    end
    rst = 1'b1; tick();
    idle();
    for (int r = 1; r <= 3; r++) begin
      rs1_addr = ADDR_W'(r);
      settle();
      n_checks++;
      if (rs1_busy !== 1'b0 || pend_cnt !== 6'd0) begin
        n_errors++; $display("FAIL reset_discard r%0d: got busy=%b cnt=%0d want 0/0", r, rs1_busy, pend_cnt);
      end
    end
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h9; tick();
    idle(); rs1_addr = 5'd2;
    settle();
    n_checks++;
    if (rs1_data !== 32'h9 || rs1_busy !== 1'b0 || pend_cnt !== 6'd0) begin
      n_errors++;
      $display("FAIL post_reset_b: got rd=%h busy=%b cnt=%0d want 9/0/0", rs1_data, rs1_busy, pend_cnt);
    end
  endtask

  function automatic logic [ADDR_W-1:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return ADDR_W'($urandom_range(0, 3));
    return ADDR_W'($urandom_range(0, NUM_REG-1));
  endfunction

  task automatic test_random();
    int errs_before;
    errs_before = n_errors;
    for (int c = 0; c < 400; c++) begin
      rst        = ($urandom_range(0, 59) == 0);
      wa_en      = $urandom_range(0, 1) == 1;
      wb_en      = $urandom_range(0, 2) == 0;
      claim_en   = $urandom_range(0, 2) == 0;
      wa_addr    = rnd_addr();
      wb_addr    = rnd_addr();
      claim_addr = rnd_addr();
      wa_data    = $urandom;
      wb_data    = $urandom;
      rs1_addr   = rnd_addr();
      rs2_addr   = rnd_addr();
      settle();
      n_checks++;
      if (rs1_data !== exp_rdata(rs1_addr) || rs2_data !== exp_rdata(rs2_addr) ||
          rs1_busy !== exp_busy(rs1_addr) || rs2_busy !== exp_busy(rs2_addr)) begin
        n_errors++;
        if (n_errors - errs_before < 10)
          $display("FAIL rand_read cyc%0d: got %h/%b %h/%b want %h/%b %h/%b", c,
                   rs1_data, rs1_busy, rs2_data, rs2_busy,
                   exp_rdata(rs1_addr), exp_busy(rs1_addr), exp_rdata(rs2_addr), exp_busy(rs2_addr));
      end
      tick();
      n_checks++;
      if (pend_cnt !== (ADDR_W+1)'(m_cnt) || wr_conflict !== m_conf || dbg_regs !== exp_dbg()) begin
        n_errors++;
        if (n_errors - errs_before < 10)
          $display("FAIL rand_state cyc%0d: got cnt=%0d conf=%b want cnt=%0d conf=%b (dbg match=%b)",
                   c, pend_cnt, wr_conflict, m_cnt, m_conf, dbg_regs === exp_dbg());
      end
    end
  endtask

  initial begin
    idle();
    rs1_addr = '0; rs2_addr = '0;
    rst = 1'b1;
    tick();
    tick();
    test_reset();
    test_write_bypass();
    test_conflict();
    test_scoreboard();
    test_claim_clear();
    test_reset_pending();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
